// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, fixed DATA_WIDTH+1 cycle latency.
// Define MULDIV_DIV_EN to build the restoring divider; without it divide ops return 0 and never write back.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [2:0]            FUNCT3,
  input  logic [DATA_WIDTH-1:0] SRC_A,
  input  logic [DATA_WIDTH-1:0] SRC_B,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  WE_OUT,
  output logic [ADDR_WIDTH-1:0] RD_OUT,
  output logic [DATA_WIDTH-1:0] RESULT
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);
  localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE2 = {{(2*N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg;
  logic [N-1:0]    hi, lo, bm;

  logic            a_sgn, b_sgn, sa, sb, neg_in, we_nx;
  logic [N-1:0]    a_mag, b_mag, hi_nx, lo_nx, res_nx;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  prod;

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  function automatic logic [2*N-1:0] cond_neg2(input logic [2*N-1:0] v, input logic en);
    return en ? (~v + ONE2) : v;
  endfunction

  // Operand capture: magnitudes and the sign the final result must carry
  always_comb begin
    a_sgn = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    b_sgn = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    sa    = a_sgn & SRC_A[N-1];
    sb    = b_sgn & SRC_B[N-1];
    a_mag = cond_neg(SRC_A, sa);
    b_mag = cond_neg(SRC_B, sb);
    if (!FUNCT3[2])
      neg_in = sa ^ sb;
    else if (!FUNCT3[1])
      neg_in = (sa ^ sb) && (SRC_B != '0);  // x/0 stays all-ones regardless of sign
    else
      neg_in = sa;
  end

  // Iteration step: shift-add multiply, or restoring shift-subtract divide
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bm} : {(N+1){1'b0}});
    hi_nx   = mul_sum[N:1];
    lo_nx   = {mul_sum[0], lo[N-1:1]};
`ifdef MULDIV_DIV_EN
    if (op[2]) begin
      logic [N:0] div_sh, div_diff;
      div_sh   = {hi, lo[N-1]};
      div_diff = div_sh - {1'b0, bm};
      hi_nx    = div_diff[N] ? div_sh[N-1:0] : div_diff[N-1:0];
      lo_nx    = {lo[N-2:0], ~div_diff[N]};
    end
`endif
  end

  // Result select and sign fix, taken from the final step's values
  always_comb begin
    prod   = cond_neg2({hi_nx, lo_nx}, neg);
    res_nx = (op[1:0] == 2'b00) ? prod[N-1:0] : prod[2*N-1:N];
    we_nx  = (RD_OUT != '0);
    if (op[2]) begin
`ifdef MULDIV_DIV_EN
      res_nx = op[1] ? cond_neg(hi_nx, neg) : cond_neg(lo_nx, neg);
`else
      res_nx = '0;
      we_nx  = 1'b0;
`endif
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      WE_OUT <= 1'b0;
      RD_OUT <= '0;
      RESULT <= '0;
    end else begin
      DONE   <= 1'b0;
      WE_OUT <= 1'b0;
      case (state)
        S_IDLE: if (START) begin
          state  <= S_BUSY;
          BUSY   <= 1'b1;
          cnt    <= '0;
          RD_OUT <= RD_ADDR;
        end
        S_BUSY: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            DONE   <= 1'b1;
            WE_OUT <= we_nx;
            RESULT <= res_nx;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers; reloaded on every accepted START
  always_ff @(posedge CLK) begin
    if (state == S_IDLE) begin
      if (START) begin
        op  <= FUNCT3;
        neg <= neg_in;
        hi  <= '0;
        lo  <= FUNCT3[2] ? a_mag : b_mag;
        bm  <= FUNCT3[2] ? b_mag : a_mag;
      end
    end else if (state == S_BUSY) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus random ops through a scoreboard queue,
// and hand-written reset-abort and START-held sequences.
module tb_muldiv_unit;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    f3 = '0;
  logic [N-1:0]  a = '0, b = '0;
  logic [AW-1:0] rd = '0;
  logic          busy, done, we;
  logic [AW-1:0] rd_out;
  logic [N-1:0]  result;

  muldiv_unit #(.DATA_WIDTH(N), .ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .FUNCT3(f3), .SRC_A(a), .SRC_B(b),
    .RD_ADDR(rd), .BUSY(busy), .DONE(done), .WE_OUT(we), .RD_OUT(rd_out), .RESULT(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [2:0]    f3;
    logic [N-1:0]  a, b;
    logic [AW-1:0] rd;
    logic [N-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [N-1:0]  res;
    logic [AW-1:0] rd;
    logic          we;
    int            t0;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, errors = 0, n_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'b000: begin p = ux * uy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == '0) return '1;
        p = sx / sy;
        return p[31:0];
      end
      3'b101: return (y == '0) ? '1 : x / y;
      3'b110: begin
        if (y == '0) return x;
        p = sx % sy;
        return p[31:0];
      end
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [N-1:0] eff_res(input logic [2:0] f, input logic [N-1:0] e);
    return (f[2] && !DIV_EN) ? '0 : e;
  endfunction

  function automatic logic eff_we(input logic [2:0] f, input logic [AW-1:0] r);
    return (r != '0) && (DIV_EN || !f[2]);
  endfunction

  task automatic push_exp(input logic [2:0] f, input logic [AW-1:0] r, input logic [N-1:0] e, input int t0);
    exp_t ex;
    ex.res = eff_res(f, e);
    ex.rd  = r;
    ex.we  = eff_we(f, r);
    ex.t0  = t0;
    sb_q.push_back(ex);
    n_exp++;
  endtask

  // Waits for the next DONE (bounded) and compares it against the scoreboard head.
  task automatic wait_done(input string tag);
    exp_t ex;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check({tag, "_unexpected_done"}, 64'(done), 64'(0));
          return;
        end
        ex = sb_q.pop_front();
        check({tag, "_result"}, 64'(result), 64'(ex.res));
        check({tag, "_rd_out"}, 64'(rd_out), 64'(ex.rd));
        check({tag, "_we"}, 64'(we), 64'(ex.we));
        check({tag, "_latency"}, 64'(cyc - ex.t0), 64'(33));
        return;
      end
    end
    check({tag, "_timeout"}, 64'(0), 64'(1));
    sb_q.delete();
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [AW-1:0] r, input logic [N-1:0] e);
    @(negedge clk);
    f3 = f; a = x; b = y; rd = r; start = 1'b1;
    push_exp(f, r, e, cyc);
    @(negedge clk);
    start = 1'b0;
    f3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(tag);
    @(negedge clk);
    check({tag, "_single_pulse"}, 64'({busy, done}), 64'(0));
  endtask

  vec_t vecs[15];
  int   dc;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,         32'd6,         5'd5,  32'd42};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd1,  32'h00000000};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd2,  32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd3,  32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,         5'd4,  32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd8,  32'd14};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd9,  32'd2};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFFFFFF};
    vecs[9]  = '{3'b110, 32'd5,         32'd0,         5'd11, 32'd5};
    vecs[10] = '{3'b100, 32'h80000000,  32'hFFFFFFFF,  5'd12, 32'h80000000};
    vecs[11] = '{3'b110, 32'h80000000,  32'hFFFFFFFF,  5'd13, 32'h00000000};
    vecs[12] = '{3'b001, 32'hFFFFFFFD,  32'd5,         5'd14, 32'hFFFFFFFF};
    vecs[13] = '{3'b000, 32'hFFFFFFFD,  32'd5,         5'd0,  32'hFFFFFFF1};
    vecs[14] = '{3'b100, 32'hFFFFFFF9,  32'd0,         5'd15, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_we", 64'(we), 64'(0));
    check("reset_rd_out", 64'(rd_out), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]    rf;
      logic [N-1:0]  ra, rb;
      logic [AW-1:0] rr;
      rf = 3'($urandom);
      ra = $urandom;
      rb = (i % 5 == 4) ? '0 : $urandom >> (i % 3) * 12;
      rr = 5'($urandom);
      run_op($sformatf("rnd%0d", i), rf, ra, rb, rr, ref_model(rf, ra, rb));
    end

    // Reset mid-operation: aborts with no DONE and clears outputs
    @(negedge clk);
    f3 = 3'b000; a = 32'd3; b = 32'd4; rd = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_rd_out", 64'(rd_out), 64'(0));
    #1 dc = done_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || we) check("abort_no_done", 64'({done, we}), 64'(0));
    end
    #1 check("abort_done_count", 64'(done_cnt), 64'(dc));

    // START held through BUSY: one DONE, next op accepted the cycle after DONE
    @(negedge clk);
    f3 = 3'b000; a = 32'd9; b = 32'd11; rd = 5'd7; start = 1'b1;
    push_exp(3'b000, 5'd7, 32'd99, cyc);
    wait_done("held1");
    f3 = 3'b011; a = 32'hFFFFFFFF; b = 32'd2; rd = 5'd0;
    push_exp(3'b011, 5'd0, 32'd1, cyc + 1);
    @(negedge clk);
    check("held_idle_gap", 64'({busy, done}), 64'(0));
    @(negedge clk);
    start = 1'b0;
    check("held2_busy", 64'(busy), 64'(1));
    wait_done("held2");
    repeat (3) @(negedge clk);

    #1 check("total_done_count", 64'(done_cnt), 64'(n_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
